reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, ROB entries; power of two, >=4.
REQ-002 SHALL have parameter NUM_SU_PIPES, default 3, state-update ports from execute.
REQ-003 SHALL have parameter RETIRE_WIDTH, default 2, max retirements per cycle.
REQ-004 SHALL have parameter PREG_W, default 6, physical register index width; IDX_W = clog2(DEPTH).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port alloc_valid  in  1  dispatch requests one entry.
REQ-008 SHALL have port alloc_dst_reg  in  PREG_W  destination physical register of allocating uOP.
REQ-009 SHALL have port alloc_ready  out  1  not full; combinational from state.
REQ-010 SHALL have port alloc_idx  out  IDX_W  index assigned to the current allocation (tail low bits).
REQ-011 SHALL have port su_valid  in  NUM_SU_PIPES  per-pipe completion strobe.
REQ-012 SHALL have port su_rob_idx  in  NUM_SU_PIPES*IDX_W  completing entry index per pipe.
REQ-013 SHALL have port su_br_mispred  in  NUM_SU_PIPES  completing branch mispredicted.
REQ-014 SHALL have port ret_valid  out  RETIRE_WIDTH  registered; slot k retired this cycle.
REQ-015 SHALL have port ret_dst_reg  out  RETIRE_WIDTH*PREG_W  registered; retired destination per slot.
REQ-016 SHALL have port flush  out  1  registered; one-cycle pulse, pipeline flush.
REQ-017 SHALL have port occupancy  out  IDX_W+1  live entries, tail-head.
REQ-018 SHALL have port err_su_invalid  out  1  sticky illegal-update flag (see Configuration).

Function
REQ-019 SHALL hold a circular buffer with head/tail pointers of IDX_W+1 bits (wrap bit); empty when equal, full when low bits equal and wrap bits differ.
REQ-020 SHALL, on alloc_valid&&alloc_ready at a clock edge, write entry[tail]: valid=1, done=0, mispred=0, dst; tail increments, wrapping modulo DEPTH.
REQ-021 SHALL ignore alloc_valid when alloc_ready=0; alloc_ready SHALL not consider same-cycle retirement.
REQ-022 SHALL, per pipe with su_valid, set done=1 and OR su_br_mispred into mispred of a valid entry; multiple pipes to one index SHALL OR.
REQ-023 SHALL ignore su updates to invalid entries.
REQ-024 SHALL each cycle select up to RETIRE_WIDTH consecutive entries from head that are valid&&done; selection stops at the first entry not done.
REQ-025 SHALL stop selection after the first selected entry with mispred=1 (that entry retires, younger do not).
REQ-026 SHALL register selected entries into ret_valid/ret_dst_reg (slot 0 oldest), clear their valid bits, advance head by count at the same edge.
REQ-027 Latency: su_valid in cycle N on the head entry SHALL give ret_valid[0]=1 in cycle N+2.
REQ-028 SHALL, when a mispred entry retires, assert flush in the same cycle as its ret_valid and at that edge clear all entries and set tail=head (empty).
REQ-029 At the flush edge, a same-cycle allocation and su updates SHALL be discarded.
REQ-030 Simultaneous alloc and retire on a non-full ROB SHALL both take effect; occupancy changes by +1-count.

Reset
REQ-031 rst SHALL asynchronously clear all valid/done/mispred bits, head=tail=0, ret_valid=0, ret_dst_reg=0, flush=0, err_su_invalid=0; thus alloc_ready=1, alloc_idx=0, occupancy=0.
REQ-032 rst asserted mid-operation SHALL discard all in-flight entries; no retirement in the cycle rst deasserts.

Configuration
REQ-033 With ROB_SU_CHECK_EN defined, err_su_invalid SHALL set at the edge after any su_valid targets an invalid entry and hold until reset.
REQ-034 Without ROB_SU_CHECK_EN, err_su_invalid SHALL be tied 0 and no check logic built; REQ-023 behaviour unchanged.

Verification
REQ-035 Fill: 16 allocs, no su -> alloc_idx 0..15, alloc_ready=0 after 16th, occupancy=16, 17th alloc dropped.
REQ-036 In-order retire: alloc 3 (dst 5,6,7); su idx2 then idx0,idx1 same cycle -> two cycles later ret_valid=11 dst 5,6; next cycle ret_valid=01 dst 7.
REQ-037 Mispredict: alloc 4; su idx0 mispred=1, idx1..3 done -> ret_valid=01, flush=1 same cycle, occupancy=0 after, next alloc_idx=1.
REQ-038 Wrap: alloc/retire 20 entries one at a time -> alloc_idx wraps 15->0, occupancy never exceeds 1.
REQ-039 Reset mid-run: 5 live entries, rst pulse -> occupancy=0, ret_valid=0, alloc_idx=0 immediately.
REQ-040 With ROB_SU_CHECK_EN: su to empty idx 9 -> err_su_invalid=1 next cycle, sticky; without macro stays 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, out-of-order completion, in-order retirement of up to RETIRE_WIDTH entries per cycle.
// Define ROB_SU_CHECK_EN to build the sticky err_su_invalid check on completions that target empty entries.
module reorder_buffer #(
  parameter int DEPTH        = 16,
  parameter int NUM_SU_PIPES = 3,
  parameter int RETIRE_WIDTH = 2,
  parameter int PREG_W       = 6,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  input  logic [PREG_W-1:0]              alloc_dst_reg,
  output logic                           alloc_ready,
  output logic [IDX_W-1:0]               alloc_idx,
  input  logic [NUM_SU_PIPES-1:0]        su_valid,
  input  logic [NUM_SU_PIPES*IDX_W-1:0]  su_rob_idx,
  input  logic [NUM_SU_PIPES-1:0]        su_br_mispred,
  output logic [RETIRE_WIDTH-1:0]        ret_valid,
  output logic [RETIRE_WIDTH*PREG_W-1:0] ret_dst_reg,
  output logic                           flush,
  output logic [IDX_W:0]                 occupancy,
  output logic                           err_su_invalid
);

  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  logic [IDX_W:0]                 head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]               valid_q, valid_d, done_q, done_d, mis_q, mis_d;
  logic [PREG_W-1:0]              dst_q [DEPTH];
  logic [RETIRE_WIDTH-1:0]        ret_valid_q, ret_valid_d;
  logic [RETIRE_WIDTH*PREG_W-1:0] ret_dst_q, ret_dst_d;
  logic                           flush_q, flush_d;
  logic [IDX_W:0]                 ret_cnt;
  logic [IDX_W-1:0]               head_idx, tail_idx;
  logic                           full, alloc_fire;

  assign head_idx    = head_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign full        = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = !full;
  assign alloc_idx   = tail_idx;
  assign occupancy   = tail_q - head_q;
  assign alloc_fire  = alloc_valid && !full && !flush_d;

  assign ret_valid   = ret_valid_q;
  assign ret_dst_reg = ret_dst_q;
  assign flush       = flush_q;

  // Retire selection: consecutive done entries from head, ending after the first mispredicted one.
  always_comb begin : select
    logic             go;
    logic [IDX_W-1:0] ridx;
    ret_valid_d = '0;
    ret_dst_d   = '0;
    flush_d     = 1'b0;
    ret_cnt     = '0;
    go          = 1'b1;
    ridx        = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ridx = head_idx + IDX_W'(k);
      if (go && valid_q[ridx] && done_q[ridx]) begin
        ret_valid_d[k]                 = 1'b1;
        ret_dst_d[k*PREG_W +: PREG_W]  = dst_q[ridx];
        ret_cnt                        = ret_cnt + PTR_ONE;
        if (mis_q[ridx]) begin
          flush_d = 1'b1;
          go      = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_comb begin : next_state
    logic [IDX_W-1:0] sidx;
    logic [IDX_W-1:0] ridx;
    valid_d = valid_q;
    done_d  = done_q;
    mis_d   = mis_q;
    head_d  = head_q + ret_cnt;
    tail_d  = tail_q;
    sidx    = '0;
    ridx    = '0;
    if (flush_d) begin
      // A retiring mispredict empties the buffer; same-edge alloc and completions are dropped.
      valid_d = '0;
      done_d  = '0;
      mis_d   = '0;
      tail_d  = head_d;
    end else begin
      for (int p = 0; p < NUM_SU_PIPES; p++) begin
        sidx = su_rob_idx[p*IDX_W +: IDX_W];
        if (su_valid[p] && valid_q[sidx]) begin
          done_d[sidx] = 1'b1;
          mis_d[sidx]  = mis_d[sidx] | su_br_mispred[p];
        end
      end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        ridx = head_idx + IDX_W'(k);
        if (ret_valid_d[k]) begin
          valid_d[ridx] = 1'b0;
          done_d[ridx]  = 1'b0;
          mis_d[ridx]   = 1'b0;
        end
      end
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        mis_d[tail_idx]   = 1'b0;
        tail_d            = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      mis_q       <= '0;
      ret_valid_q <= '0;
      ret_dst_q   <= '0;
      flush_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      ret_valid_q <= ret_valid_d;
      ret_dst_q   <= ret_dst_d;
      flush_q     <= flush_d;
    end
  end

  // Destination payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) dst_q[tail_idx] <= alloc_dst_reg;
  end

`ifdef ROB_SU_CHECK_EN
  logic err_q, su_bad;

  always_comb begin
    su_bad = 1'b0;
    for (int p = 0; p < NUM_SU_PIPES; p++) begin
      if (su_valid[p] && !valid_q[su_rob_idx[p*IDX_W +: IDX_W]]) su_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | su_bad;
  end

  assign err_su_invalid = err_q;
`else
  assign err_su_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based ROB model predicts retirements, a monitor checks them.
module tb_reorder_buffer;
  localparam int DEPTH  = 16;
  localparam int NSU    = 3;
  localparam int RW     = 2;
  localparam int PREG_W = 6;
  localparam int IDX_W  = 4;
`ifdef ROB_SU_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    alloc_valid = 1'b0;
  logic [PREG_W-1:0]       alloc_dst_reg = '0;
  logic                    alloc_ready;
  logic [IDX_W-1:0]        alloc_idx;
  logic [NSU-1:0]          su_valid = '0;
  logic [NSU*IDX_W-1:0]    su_rob_idx = '0;
  logic [NSU-1:0]          su_br_mispred = '0;
  logic [RW-1:0]           ret_valid;
  logic [RW*PREG_W-1:0]    ret_dst_reg;
  logic                    flush;
  logic [IDX_W:0]          occupancy;
  logic                    err_su_invalid;

  reorder_buffer #(.DEPTH(DEPTH), .NUM_SU_PIPES(NSU), .RETIRE_WIDTH(RW), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_dst_reg(alloc_dst_reg),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx), .su_valid(su_valid), .su_rob_idx(su_rob_idx),
    .su_br_mispred(su_br_mispred), .ret_valid(ret_valid), .ret_dst_reg(ret_dst_reg), .flush(flush),
    .occupancy(occupancy), .err_su_invalid(err_su_invalid)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [PREG_W-1:0] dst; bit done; bit mis; } ent_t;
  typedef struct { logic [PREG_W-1:0] dst; bit mis; } rec_t;

  ent_t m_rob[$];
  rec_t exp_q[$];
  int   m_head, m_tail;
  bit   m_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit in_rob(input int idx);
    foreach (m_rob[i]) if (m_rob[i].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the reference ROB, evaluated from the inputs currently driven.
  task automatic model_cycle();
    bit   ready, fl, bad, stop;
    int   n, sidx;
    ent_t e;
    ready = (m_rob.size() < DEPTH);
    chk("alloc_ready", alloc_ready, ready);
    chk("alloc_idx", alloc_idx, m_tail % DEPTH);
    chk("occupancy", occupancy, m_rob.size());
    chk("err_su_invalid", err_su_invalid, m_err);
    n = 0; fl = 0; stop = 0;
    while (!stop && n < RW && n < m_rob.size()) begin
      if (!m_rob[n].done) stop = 1;
      else begin
        exp_q.push_back('{m_rob[n].dst, m_rob[n].mis});
        if (m_rob[n].mis) begin fl = 1; stop = 1; end
        n++;
      end
    end
    bad = 0;
    for (int p = 0; p < NSU; p++)
      if (su_valid[p] && !in_rob(int'(su_rob_idx[p*IDX_W +: IDX_W]))) bad = 1;
    repeat (n) void'(m_rob.pop_front());
    m_head += n;
    if (fl) begin
      m_rob.delete();
      m_tail = m_head;
    end else begin
      for (int p = 0; p < NSU; p++) begin
        if (su_valid[p]) begin
          sidx = int'(su_rob_idx[p*IDX_W +: IDX_W]);
          foreach (m_rob[i]) if (m_rob[i].idx == sidx) begin
            e = m_rob[i]; e.done = 1; e.mis = e.mis | su_br_mispred[p]; m_rob[i] = e;
          end
        end
      end
      if (alloc_valid && ready) begin
        m_rob.push_back('{m_tail % DEPTH, alloc_dst_reg, 1'b0, 1'b0});
        m_tail++;
      end
    end
    if (CHK_EN && bad) m_err = 1;
  endtask

  task automatic step(input logic av, input logic [PREG_W-1:0] ad, input logic [NSU-1:0] sv,
                      input logic [NSU*IDX_W-1:0] si, input logic [NSU-1:0] sm);
    @(negedge clk);
    alloc_valid = av; alloc_dst_reg = ad; su_valid = sv; su_rob_idx = si; su_br_mispred = sm;
    #1;
    model_cycle();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_valid = 1'b0; su_valid = '0; su_br_mispred = '0;
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_dst", ret_dst_reg, 0);
    chk("rst_flush", flush, 0);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_err", err_su_invalid, 0);
    m_rob.delete(); exp_q.delete();
    m_head = 0; m_tail = 0; m_err = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every retirement slot pops one predicted record; flush must match the predicted mispredict.
  initial begin
    rec_t r;
    bit   fl_exp;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        fl_exp = 0;
        for (int k = 0; k < RW; k++) begin
          if (ret_valid[k]) begin
            if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
            else begin
              r = exp_q.pop_front();
              chk("ret_dst", ret_dst_reg[k*PREG_W +: PREG_W], r.dst);
              fl_exp |= r.mis;
            end
          end
        end
        chk("flush", flush, fl_exp);
      end
    end
  end

  initial begin
    logic [NSU-1:0]       sv, sm;
    logic [NSU*IDX_W-1:0] si;
    m_head = 0; m_tail = 0; m_err = 0;
    do_reset();

    // Fill to capacity, 17th alloc must be dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, PREG_W'(i), '0, '0, '0);
    step(1'b1, 6'h3f, '0, '0, '0);
    chk("fill_occupancy", occupancy, 16);
    chk("fill_ready", alloc_ready, 0);

    // In-order retire of three entries
    do_reset();
    step(1'b1, 6'd5, '0, '0, '0);
    step(1'b1, 6'd6, '0, '0, '0);
    step(1'b1, 6'd7, '0, '0, '0);
    step(1'b0, '0, 3'b001, {4'd0, 4'd0, 4'd2}, '0);
    step(1'b0, '0, 3'b011, {4'd0, 4'd1, 4'd0}, '0);
    idle();
    @(posedge clk); #1;
    chk("inorder_rv0", ret_valid, 2'b11);
    chk("inorder_dst0", ret_dst_reg, {6'd6, 6'd5});
    idle();
    @(posedge clk); #1;
    chk("inorder_rv1", ret_valid, 2'b01);
    chk("inorder_dst1", ret_dst_reg, {6'd0, 6'd7});

    // Mispredict on the head entry flushes the rest
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, PREG_W'(10 + i), '0, '0, '0);
    step(1'b0, '0, 3'b001, {4'd0, 4'd0, 4'd3}, '0);
    step(1'b0, '0, 3'b111, {4'd2, 4'd1, 4'd0}, 3'b001);
    idle();
    @(posedge clk); #1;
    chk("mis_rv", ret_valid, 2'b01);
    chk("mis_flush", flush, 1);
    chk("mis_dst", ret_dst_reg[PREG_W-1:0], 10);
    idle();
    chk("mis_occ_after", occupancy, 0);
    chk("mis_alloc_idx_after", alloc_idx, 1);

    // Wrap: 20 entries through one at a time
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("wrap_alloc_idx", alloc_idx, i % DEPTH);
      step(1'b1, PREG_W'(i), '0, '0, '0);
      chk("wrap_occ_a", occupancy <= 1, 1);
      step(1'b0, '0, 3'b001, {8'd0, 4'(i % DEPTH)}, '0);
      chk("wrap_occ_b", occupancy <= 1, 1);
      idle();
      idle();
    end

    // Reset mid-run with a retirement on the outputs
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, PREG_W'(20 + i), '0, '0, '0);
    step(1'b0, '0, 3'b001, {4'd0, 4'd0, 4'd0}, '0);
    idle();
    @(posedge clk); #1;
    chk("midrst_pre_rv", ret_valid, 2'b01);
    do_reset();

    // Completion aimed at an empty entry
    step(1'b0, '0, 3'b001, {4'd0, 4'd0, 4'd9}, '0);
    idle();
    chk("err_set", err_su_invalid, CHK_EN);
    idle(); idle();
    chk("err_sticky", err_su_invalid, CHK_EN);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      sv = '0; sm = '0; si = '0;
      for (int p = 0; p < NSU; p++) begin
        sv[p] = ($urandom_range(1) == 1);
        if (m_rob.size() > 0 && $urandom_range(7) != 0)
          si[p*IDX_W +: IDX_W] = 4'(m_rob[$urandom_range(m_rob.size() - 1)].idx);
        else
          si[p*IDX_W +: IDX_W] = 4'($urandom_range(DEPTH - 1));
        sm[p] = ($urandom_range(11) == 0);
      end
      step($urandom_range(3) != 0, PREG_W'($urandom), sv, si, sm);
    end
    idle(); idle(); idle();
    @(posedge clk); #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
